// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and the 7-segment to hex decode function
// for the scanned-display receiver.
package seg7_pkg;

    typedef logic [7:0] seg_t;

    // Active-low hgfedcba patterns with the decimal point dark.
    localparam seg_t SEG_0     = 8'hC0;
    localparam seg_t SEG_1     = 8'hF9;
    localparam seg_t SEG_2     = 8'hA4;
    localparam seg_t SEG_3     = 8'hB0;
    localparam seg_t SEG_4     = 8'h99;
    localparam seg_t SEG_5     = 8'h92;
    localparam seg_t SEG_6     = 8'h82;
    localparam seg_t SEG_7     = 8'hF8;
    localparam seg_t SEG_8     = 8'h80;
    localparam seg_t SEG_9     = 8'h90;
    localparam seg_t SEG_A     = 8'h88;
    localparam seg_t SEG_B     = 8'h83;
    localparam seg_t SEG_C     = 8'hC6;
    localparam seg_t SEG_D     = 8'hA1;
    localparam seg_t SEG_E     = 8'h86;
    localparam seg_t SEG_F     = 8'h8E;
    localparam seg_t SEG_BLANK = 8'hFF;

    // Returns {valid, nibble}; the decimal point (bit 7) does not affect the glyph.
    function automatic logic [4:0] seg7_to_hex(input seg_t seg);
        logic [4:0] res;
        case (seg[6:0])
            SEG_0[6:0]: res = {1'b1, 4'h0};
            SEG_1[6:0]: res = {1'b1, 4'h1};
            SEG_2[6:0]: res = {1'b1, 4'h2};
            SEG_3[6:0]: res = {1'b1, 4'h3};
            SEG_4[6:0]: res = {1'b1, 4'h4};
            SEG_5[6:0]: res = {1'b1, 4'h5};
            SEG_6[6:0]: res = {1'b1, 4'h6};
            SEG_7[6:0]: res = {1'b1, 4'h7};
            SEG_8[6:0]: res = {1'b1, 4'h8};
            SEG_9[6:0]: res = {1'b1, 4'h9};
            SEG_A[6:0]: res = {1'b1, 4'hA};
            SEG_B[6:0]: res = {1'b1, 4'hB};
            SEG_C[6:0]: res = {1'b1, 4'hC};
            SEG_D[6:0]: res = {1'b1, 4'hD};
            SEG_E[6:0]: res = {1'b1, 4'hE};
            SEG_F[6:0]: res = {1'b1, 4'hF};
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Pin-side scanned-display bus plus the rebuilt per-digit outputs.
// master drives the gpio lines and consumes results; slave is the decoder.
interface seg7_scan_decoder_if #(
    parameter int N_DIGITS = 6
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [7:0]            seg_n;
    logic [N_DIGITS-1:0]   dig_n;
    logic [N_DIGITS*8-1:0] raw_seg;
    logic [N_DIGITS*4-1:0] hex;
    logic [N_DIGITS-1:0]   hex_valid;
    logic [N_DIGITS-1:0]   dp;
    logic                  upd;
    logic [IDX_W-1:0]      upd_idx;
    logic                  err;

    modport master (
        output seg_n, dig_n,
        input  raw_seg, hex, hex_valid, dp, upd, upd_idx, err
    );

    modport slave (
        input  seg_n, dig_n,
        output raw_seg, hex, hex_valid, dp, upd, upd_idx, err
    );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational decode of one captured 7-segment pattern to a hex nibble.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  seg_t       seg,
    output logic [3:0] nibble,
    output logic       valid
);

    logic [4:0] dec_s;

    // Table lookup lives in the package so every user decodes identically.
    always_comb begin
        dec_s  = seg7_to_hex(seg);
        valid  = dec_s[4];
        nibble = dec_s[3:0];
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receiver for a time-multiplexed 7-segment bus: synchronize, filter, capture, decode.
// Optional stale-digit blanking is enabled with SEG7_SCAN_STALE_TIMEOUT_EN.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 6,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT_W     = 20
)(
    input  logic                clk,
    input  logic                reset,
    seg7_scan_decoder_if.slave  bus
);

    localparam int         IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int         BUS_W    = N_DIGITS + 8;
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || TIMEOUT_W < 1) begin : g_param_check
        $error("seg7_scan_decoder: STABLE_CYCLES must be 2..255 and TIMEOUT_W >= 1");
    end

    logic [BUS_W-1:0]    sync1_r;
    logic [BUS_W-1:0]    s2_r;
    logic [BUS_W-1:0]    prev_r;
    logic [7:0]          cnt_r;
    logic                done_r;

    logic [N_DIGITS-1:0] sel_s;
    logic                any_s;
    logic                multi_s;
    logic [IDX_W-1:0]    sel_idx_s;
    logic                eval_s;
    logic                write_s;

    seg_t                raw_r [N_DIGITS];
    logic                upd_r;
    logic [IDX_W-1:0]    upd_idx_r;
    logic                err_r;

    seg_t                disp_s   [N_DIGITS];
    logic [3:0]          nib_s    [N_DIGITS];
    logic                val_s    [N_DIGITS];

    // Two-flop synchronizer and the stability window filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= '1;
            s2_r    <= '1;
            prev_r  <= '1;
            cnt_r   <= 8'd0;
            done_r  <= 1'b1;
        end else begin
            sync1_r <= {bus.dig_n, bus.seg_n};
            s2_r    <= sync1_r;
            if (s2_r != prev_r) begin
                prev_r <= s2_r;
                cnt_r  <= 8'd0;
                done_r <= 1'b0;
            end else if (cnt_r < CNT_LAST) begin
                cnt_r <= cnt_r + 8'd1;
            end else if (!done_r) begin
                done_r <= 1'b1;
            end
        end
    end

    // One evaluation per stable window; classify the digit-select pattern.
    always_comb begin
        sel_s     = ~s2_r[8 +: N_DIGITS];
        any_s     = |sel_s;
        multi_s   = |(sel_s & (sel_s - N_DIGITS'(1)));
        eval_s    = (s2_r == prev_r) && (cnt_r >= CNT_LAST) && !done_r;
        write_s   = eval_s && any_s && !multi_s;
        sel_idx_s = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            sel_idx_s = sel_s[i] ? IDX_W'(i) : sel_idx_s;
        end
    end

    // Capture registers and the one-cycle event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                raw_r[i] <= SEG_BLANK;
            end
            upd_r     <= 1'b0;
            upd_idx_r <= '0;
            err_r     <= 1'b0;
        end else begin
            upd_r <= write_s;
            err_r <= eval_s && multi_s;
            if (write_s) begin
                raw_r[sel_idx_s] <= s2_r[7:0];
                upd_idx_r        <= sel_idx_s;
            end
        end
    end

`ifdef SEG7_SCAN_STALE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] age_r [N_DIGITS];

    // Per-digit age since last capture; saturation marks the digit stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                age_r[i] <= '1;
            end
        end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (write_s && (sel_idx_s == IDX_W'(i))) begin
                    age_r[i] <= '0;
                end else if (!(&age_r[i])) begin
                    age_r[i] <= age_r[i] + 1'b1;
                end
            end
        end
    end

    // Stale digits present as blank, which also clears their valid flag.
    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            disp_s[i] = (&age_r[i]) ? SEG_BLANK : raw_r[i];
        end
    end
`else
    // Captured patterns are held until overwritten.
    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            disp_s[i] = raw_r[i];
        end
    end
`endif

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        seg7_glyph_decode u_decode (
            .seg    (disp_s[g]),
            .nibble (nib_s[g]),
            .valid  (val_s[g])
        );
    end

    // Flatten per-digit results onto the interface.
    always_comb begin
        bus.raw_seg   = '0;
        bus.hex       = '0;
        bus.hex_valid = '0;
        bus.dp        = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            bus.raw_seg[8*i +: 8] = disp_s[i];
            bus.hex[4*i +: 4]     = nib_s[i];
            bus.hex_valid[i]      = val_s[i];
            bus.dp[i]             = ~disp_s[i][7];
        end
        bus.upd     = upd_r;
        bus.upd_idx = upd_idx_r;
        bus.err     = err_r;
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus pushes expected captures,
// a negedge monitor pops them on every upd/err pulse.
module tb_seg7_scan_decoder;

`ifdef SEG7_SCAN_STALE_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 20;
`endif

    typedef struct {
        int         idx;
        logic [7:0] raw;
        logic [3:0] nib;
        logic       val;
        logic       dp;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   err_pending;
    exp_t exp_q[$];

    seg7_scan_decoder_if #(.N_DIGITS(6)) bus ();

    seg7_scan_decoder #(
        .N_DIGITS      (6),
        .STABLE_CYCLES (4),
        .TIMEOUT_W     (TW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] raw, input logic [3:0] nib,
                        input logic val, input logic dp);
        exp_t e;
        e.idx = idx; e.raw = raw; e.nib = nib; e.val = val; e.dp = dp;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [5:0] d, input logic [7:0] s, input int n);
        bus.dig_n = d;
        bus.seg_n = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        hold(6'h3F, 8'hFF, n);
    endtask

    // Monitor: every upd must match the oldest expectation; every err must be expected.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.upd) begin
                if (exp_q.size() == 0) begin
                    chk("upd_unexpected", 64'(bus.upd_idx), 64'hFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("upd_idx", 64'(bus.upd_idx), 64'(e.idx));
                    chk("upd_raw", 64'(bus.raw_seg[8*e.idx +: 8]), 64'(e.raw));
                    chk("upd_hex", 64'(bus.hex[4*e.idx +: 4]), 64'(e.nib));
                    chk("upd_valid", 64'(bus.hex_valid[e.idx]), 64'(e.val));
                    chk("upd_dp", 64'(bus.dp[e.idx]), 64'(e.dp));
                end
            end
            if (bus.err) begin
                chk("err_expected", 64'(err_pending > 0), 64'd1);
                chk("upd_with_err", 64'(bus.upd), 64'd0);
                if (err_pending > 0) err_pending--;
            end
        end
    end

    initial begin
        int lat;
        checks      = 0;
        errors      = 0;
        err_pending = 0;
        reset       = 1'b1;
        bus.dig_n   = 6'h3F;
        bus.seg_n   = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_raw", 64'(bus.raw_seg), 64'hFFFF_FFFF_FFFF);
        chk("rst_hex", 64'(bus.hex), 64'd0);
        chk("rst_valid", 64'(bus.hex_valid), 64'd0);
        chk("rst_dp", 64'(bus.dp), 64'd0);
        chk("rst_upd", 64'(bus.upd), 64'd0);
        chk("rst_idx", 64'(bus.upd_idx), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        reset = 1'b0;
        blank(4);

        // Single capture of "0" on digit 0 with latency measurement.
        push(0, 8'hC0, 4'h0, 1'b1, 1'b0);
        bus.dig_n = 6'h3E;
        bus.seg_n = 8'hC0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.upd && lat < 0) lat = k - 1;
        end
        chk("latency_edges", 64'(lat), 64'd6);
        @(posedge clk);
        #1;
        blank(3);

        // Scan six digits: 1 2 3 A b C.
        push(0, 8'hF9, 4'h1, 1'b1, 1'b0); hold(6'h3E, 8'hF9, 10); blank(3);
        push(1, 8'hA4, 4'h2, 1'b1, 1'b0); hold(6'h3D, 8'hA4, 10); blank(3);
        push(2, 8'hB0, 4'h3, 1'b1, 1'b0); hold(6'h3B, 8'hB0, 10); blank(3);
        push(3, 8'h88, 4'hA, 1'b1, 1'b0); hold(6'h37, 8'h88, 10); blank(3);
        push(4, 8'h83, 4'hB, 1'b1, 1'b0); hold(6'h2F, 8'h83, 10); blank(3);
        push(5, 8'hC6, 4'hC, 1'b1, 1'b0); hold(6'h1F, 8'hC6, 10); blank(3);
`ifndef SEG7_SCAN_STALE_TIMEOUT_EN
        chk("scan_hex", 64'(bus.hex), 64'hCBA321);
        chk("scan_valid", 64'(bus.hex_valid), 64'h3F);
`endif

        // Short glitch on digit 1 must not capture 80.
        push(1, 8'h92, 4'h5, 1'b1, 1'b0);
        hold(6'h3D, 8'h92, 8);
        hold(6'h3D, 8'h80, 2);
        push(1, 8'h92, 4'h5, 1'b1, 1'b0);
        hold(6'h3D, 8'h92, 10);
        blank(3);

        // Two digits selected: error, no write.
        err_pending++;
        hold(6'h3C, 8'hA4, 10);
        blank(3);
`ifndef SEG7_SCAN_STALE_TIMEOUT_EN
        chk("err_raw_kept", 64'(bus.raw_seg), 64'hC6_83_88_B0_92_F9);
`endif

        // Invalid patterns on digit 2, then C with decimal point lit.
        push(2, 8'h7F, 4'h0, 1'b0, 1'b1); hold(6'h3B, 8'h7F, 10); blank(3);
        push(2, 8'h49, 4'h0, 1'b0, 1'b1); hold(6'h3B, 8'h49, 10); blank(3);
        push(2, 8'h46, 4'hC, 1'b1, 1'b1); hold(6'h3B, 8'h46, 10); blank(3);

        // Long hold captures once; re-scan after blank captures again.
        push(0, 8'hF9, 4'h1, 1'b1, 1'b0); hold(6'h3E, 8'hF9, 30); blank(5);
        push(0, 8'hF9, 4'h1, 1'b1, 1'b0); hold(6'h3E, 8'hF9, 10); blank(3);

        // Reset in the middle of a window: no capture, everything blank.
        bus.dig_n = 6'h3E;
        bus.seg_n = 8'hC0;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.dig_n = 6'h3F;
        bus.seg_n = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        blank(15);
        chk("midrst_raw", 64'(bus.raw_seg), 64'hFFFF_FFFF_FFFF);
        chk("midrst_valid", 64'(bus.hex_valid), 64'd0);

`ifdef SEG7_SCAN_STALE_TIMEOUT_EN
        push(0, 8'hC0, 4'h0, 1'b1, 1'b0);
        hold(6'h3E, 8'hC0, 10);
        blank(20);
        chk("stale_raw", 64'(bus.raw_seg[7:0]), 64'hFF);
        chk("stale_valid", 64'(bus.hex_valid[0]), 64'd0);
`endif

        for (int k = 0; k < 50 && (exp_q.size() != 0 || err_pending != 0); k++) begin
            @(posedge clk);
        end
        #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("err_drained", 64'(err_pending), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
